// File: rtl/alorium_lfsr_arb.sv
// Round-robin arbiter/sequencer sharing one LFSR among NREQ requesters; 3-cycle data latency, 2-cycle reseed.
// No backpressure: requests are pulses that latch into one-deep pending bits, and duplicates merge.
module alorium_lfsr_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       seed_req,
    input  logic [NREQ*WIDTH-1:0] seed_in,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       seed_ack,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  lfsr_enable,
    output logic                  lfsr_new_seed,
    output logic [WIDTH-1:0]      lfsr_seed,
    input  logic [WIDTH-1:0]      lfsr_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEED = 2'd1;
    localparam logic [1:0] STEP = 2'd2;
    localparam logic [1:0] CAPT = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    g;
    logic [PW-1:0]    ptr;
    logic [NREQ-1:0]  data_pend;
    logic [NREQ-1:0]  seed_pend;
    logic [WIDTH-1:0] seed_reg [NREQ];

    logic [NREQ-1:0]  cand;
    logic [NREQ-1:0]  g_oh;
    logic [NREQ-1:0]  dclr;
    logic [NREQ-1:0]  sclr;
    logic             found;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    idx;

    // Search starts just past the last served requester, so each one waits at most NREQ operations.
    always_comb begin
        cand  = data_pend | seed_pend;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        g_oh = NREQ'(1) << g;
        dclr = (state == CAPT) ? g_oh : '0;
        sclr = (state == SEED) ? g_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            g             <= '0;
            ptr           <= PW'(NREQ - 1);
            data_pend     <= '0;
            seed_pend     <= '0;
            ack           <= '0;
            seed_ack      <= '0;
            rdata         <= '0;
            busy          <= 1'b0;
            lfsr_enable   <= 1'b0;
            lfsr_new_seed <= 1'b0;
            lfsr_seed     <= '0;
            for (int i = 0; i < NREQ; i++) seed_reg[i] <= '0;
        end else begin
            ack      <= '0;
            seed_ack <= '0;
            // A new pulse in the completion cycle re-arms the bit rather than being lost.
            data_pend <= (data_pend & ~dclr) | req;
            seed_pend <= (seed_pend & ~sclr) | seed_req;
            for (int i = 0; i < NREQ; i++) begin
                if (seed_req[i]) seed_reg[i] <= seed_in[i*WIDTH +: WIDTH];
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        g    <= pick;
                        busy <= 1'b1;
                        if (seed_pend[pick]) begin
                            state         <= SEED;
                            lfsr_seed     <= seed_reg[pick];
                            lfsr_new_seed <= 1'b1;
                        end else begin
                            state       <= STEP;
                            lfsr_enable <= 1'b1;
                        end
                    end
                end
                SEED: begin
                    seed_ack      <= g_oh;
                    ptr           <= g;
                    lfsr_new_seed <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                STEP: begin
                    lfsr_enable <= 1'b0;
                    state       <= CAPT;
                end
                CAPT: begin
                    rdata <= lfsr_data;
                    ack   <= g_oh;
                    ptr   <= g;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alorium_lfsr_arb.md
# alorium_lfsr_arb

Round-robin arbiter and sequencer that shares one 8-bit LFSR among NREQ requesters. It sits between the requesting logic and the LFSR's control pins. Requesters post single-cycle pulses for a new random byte or a reseed. The block serialises these into LFSR `enable` / `new_seed` strobes and returns each captured value with a one-hot acknowledge.

## Interface

**Parameters**
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, LFSR data/seed width

**Ports**
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester one-cycle pulse: request one random byte
- seed_req  in  NREQ  per-requester one-cycle pulse: reseed the LFSR with this requester's seed_in slice
- seed_in  in  NREQ*WIDTH  seed values; slice i is seed_in[i*WIDTH +: WIDTH], sampled when seed_req[i]=1
- ack  out  NREQ  one-hot one-cycle pulse: rdata is valid for that requester
- seed_ack  out  NREQ  one-hot one-cycle pulse: that requester's reseed has been applied
- rdata  out  WIDTH  captured LFSR value; holds until the next ack
- busy  out  1  high when state is not IDLE
- lfsr_enable  out  1  step strobe to the LFSR
- lfsr_new_seed  out  1  load strobe to the LFSR
- lfsr_seed  out  WIDTH  seed value presented to the LFSR
- lfsr_data  in  WIDTH  current LFSR output; registered in the LFSR, updates the cycle after an enable or new_seed edge

## Operation

**Pending state**
- Per-requester registers: data_pend[i], seed_pend[i], seed_reg[i].
- req[i] sets data_pend[i].
- seed_req[i] sets seed_pend[i] and loads seed_reg[i] from seed_in. If a seed is already pending, the last value wins.
- A req pulse while data_pend[i] is already set merges with it; there is no queuing beyond one.
- Set wins over clear: a pulse in the same cycle that the requester's own operation completes leaves the bit set.

**FSM: IDLE, SEED, STEP, CAPT**
- **IDLE**
  - Candidates are data_pend | seed_pend.
  - Search round-robin starting at (ptr+1) mod NREQ and pick the first candidate i.
  - Register grant index g=i.
  - If seed_pend[i]=1: go to SEED, set lfsr_seed<=seed_reg[i], lfsr_new_seed<=1.
  - Otherwise: go to STEP, set lfsr_enable<=1.
  - With no candidates, stay in IDLE.
- **SEED**
  - lfsr_new_seed is high for exactly this cycle.
  - At the edge: clear seed_pend[g], set seed_ack[g]<=1, ptr<=g, lfsr_new_seed<=0, go to IDLE.
- **STEP**
  - lfsr_enable is high for exactly this cycle.
  - At the edge: lfsr_enable<=0, go to CAPT.
- **CAPT**
  - At the edge: rdata<=lfsr_data, ack[g]<=1, clear data_pend[g], ptr<=g, go to IDLE.

**Rules and boundary cases**
- A requester with both seed_pend and data_pend set is served as a seed first. Its data request stays pending and is served on a later turn, after the other requesters per the pointer.
- lfsr_seed is registered at IDLE→SEED. A seed_req[g] arriving during SEED updates seed_reg[g] only and leaves a new pending seed.
- lfsr_enable and lfsr_new_seed are never high in the same cycle.
- ack and seed_ack are never high in the same cycle.
- Reset (any state, mid-operation):
  - next cycle: state IDLE; all pending bits 0; ack=0, seed_ack=0, lfsr_enable=0, lfsr_new_seed=0; rdata=0, lfsr_seed=0, busy=0; ptr=NREQ-1, so requester 0 has first priority.
  - In-flight operations are dropped without ack.

## Timing
- All outputs are registered.
- Data request, uncontended: req sampled at edge E0 → IDLE arbitrates at E1 → lfsr_enable high in cycle E1..E2 → CAPT captures at E3 → ack and rdata visible after E3.
  - Latency is 3 cycles; occupancy is 3 cycles per operation.
- Reseed, uncontended: seed_req at E0 → lfsr_new_seed high in cycle E1..E2 → seed_ack visible after E2.
- Back-to-back operations: IDLE lasts one cycle between operations.
- Worst-case wait for a data request: NREQ operations ahead of it.

## Test plan
The bench uses a behavioural LFSR model: new_seed loads the seed; enable increments the value.
- Reset, then req[0] pulse → lfsr_enable exactly one cycle; ack=4'b0001 three cycles after the req edge; rdata=previous+1; busy high for 2 cycles.
- seed_req[2] with seed_in slice 8'hAA, then req[2] → lfsr_new_seed pulse with lfsr_seed=8'hAA, seed_ack=4'b0100; then ack=4'b0100 with rdata=8'hAB.
- req=4'b1111 in one cycle → acks in order 0,1,2,3 at 3-cycle spacing; rdata values are consecutive.
- req[1] pulsed every cycle while 1 and 3 contend → acks alternate 1,3,1,3; no starvation; at most one ack high per cycle.
- req[0] pulse again in the same cycle as ack[0] → a second ack[0] follows; a duplicate req pulse while pending → only one ack.
- reset asserted during STEP → next cycle all outputs at reset values, no ack; a subsequent req[3] is served normally.
